// File: rtl/rst_sync.sv
// Reset synchronizer: asserts SYNC_RST (active-low) asynchronously with RST and
// releases it only after STAGES_NUM rising CLK edges with RST held high.
`timescale 1ns/1ps

module rst_sync #(
   parameter int STAGES_NUM = 2
) (
   input  logic CLK,
   input  logic RST,
   output logic SYNC_RST
);

   // Kept as discrete async-reset flops so tools place them together and do not
   // fold the chain into a shift-register primitive without a reset.
   (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
   logic [STAGES_NUM-1:0] r_sync_reg;

   generate
      if (STAGES_NUM < 2) begin : g_illegal_stages
         $error("rst_sync: STAGES_NUM must be >= 2");
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync_reg <= '0;
      end else begin
         r_sync_reg <= {r_sync_reg[STAGES_NUM-2:0], 1'b1};
      end
   end

   assign SYNC_RST = r_sync_reg[STAGES_NUM-1];

endmodule

// File: tb/tb_rst_sync.sv
// Directed self-checking bench for rst_sync with 2- and 4-stage instances
// sharing one raw reset and one gateable 5 ns clock.
`timescale 1ns/1ps

module tb_rst_sync;

   logic clk;
   logic clk_run;
   logic rst_n;
   logic sync2;
   logic sync4;
   int   checks;
   int   errors;

   rst_sync #(.STAGES_NUM(2)) u_dut2 (.CLK(clk), .RST(rst_n), .SYNC_RST(sync2));
   rst_sync #(.STAGES_NUM(4)) u_dut4 (.CLK(clk), .RST(rst_n), .SYNC_RST(sync4));

   initial clk = 1'b0;
   always begin
      #2.5;
      if (clk_run) clk = ~clk;
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      clk_run = 1'b1;
      rst_n   = 1'b0;

      // Power-up: held in reset while the clock runs
      #0.5;
      check("por_async_s2", sync2, 1'b0);
      check("por_async_s4", sync4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         edge_sample();
         check("por_s2", sync2, 1'b0);
         check("por_s4", sync4, 1'b0);
      end

      // Release: 2-stage rises on edge 2, 4-stage on edge 4
      @(negedge clk);
      rst_n = 1'b1;
      edge_sample();
      check("rel_e1_s2", sync2, 1'b0);
      check("rel_e1_s4", sync4, 1'b0);
      edge_sample();
      check("rel_e2_s2", sync2, 1'b1);
      check("rel_e2_s4", sync4, 1'b0);
      edge_sample();
      check("rel_e3_s4", sync4, 1'b0);
      edge_sample();
      check("rel_e4_s4", sync4, 1'b1);
      for (int i = 0; i < 3; i++) begin
         edge_sample();
         check("steady_s2", sync2, 1'b1);
         check("steady_s4", sync4, 1'b1);
      end

      // Asynchronous assertion in mid-period, before the next edge
      edge_sample();
      rst_n = 1'b0;
      #0.5;
      check("async_s2", sync2, 1'b0);
      check("async_s4", sync4, 1'b0);

      // Aborted release: one edge high, then back low, then full re-release
      @(negedge clk);
      rst_n = 1'b1;
      edge_sample();
      check("abort_e1_s2", sync2, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      edge_sample();
      check("abort_low_s2", sync2, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      edge_sample();
      check("rerel_e1_s2", sync2, 1'b0);
      edge_sample();
      check("rerel_e2_s2", sync2, 1'b1);
      check("rerel_e2_s4", sync4, 1'b0);
      edge_sample();
      edge_sample();
      check("rerel_e4_s4", sync4, 1'b1);

      // Short pulse (1 ns) fully clears the chain
      edge_sample();
      rst_n = 1'b0;
      #0.5;
      check("pulse_low_s2", sync2, 1'b0);
      #0.5;
      rst_n = 1'b1;
      #0.2;
      check("pulse_after_s2", sync2, 1'b0);
      check("pulse_after_s4", sync4, 1'b0);
      edge_sample();
      check("pulse_e1_s2", sync2, 1'b0);
      edge_sample();
      check("pulse_e2_s2", sync2, 1'b1);
      check("pulse_e2_s4", sync4, 1'b0);
      edge_sample();
      edge_sample();
      check("pulse_e4_s4", sync4, 1'b1);

      // Clock stopped: reset still asserts immediately
      @(negedge clk);
      clk_run = 1'b0;
      #20;
      check("frozen_hold_s2", sync2, 1'b1);
      rst_n = 1'b0;
      #0.1;
      check("frozen_s2", sync2, 1'b0);
      check("frozen_s4", sync4, 1'b0);
      #10;
      rst_n = 1'b1;
      #10;
      check("frozen_rel_s2", sync2, 1'b0);
      clk_run = 1'b1;
      edge_sample();
      check("resume_e1_s2", sync2, 1'b0);
      edge_sample();
      check("resume_e2_s2", sync2, 1'b1);
      edge_sample();
      check("resume_e3_s4", sync4, 1'b0);
      edge_sample();
      check("resume_e4_s4", sync4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
